// File: rtl/grid_scan_reader.sv
`default_nettype none
// ============================================================================
//  Module      : grid_scan_reader
//  Description : Walks a ROWS x COLS tetris grid once per frame request. For
//                each cell it issues a one-cycle memory read, captures the
//                returned byte and presents it on a valid/ready pixel stream
//                with start-of-frame and end-of-line qualifiers.
//  Revision    : 1.0 - initial release
// ============================================================================
module grid_scan_reader #(
    parameter int COLS = 10,
    parameter int ROWS = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_req,
    output logic [7:0] grid_address,
    output logic       read_en,
    input  logic [7:0] tetris_grid_in,
    output logic [7:0] pix_data,
    output logic       pix_valid,
    input  logic       pix_ready,
    output logic       pix_sof,
    output logic       pix_eol,
    output logic       busy,
    output logic       frame_done
);

    // Grid geometry must fit the 8-bit address space of the grid memory.
    generate
        if ((ROWS * COLS > 256) || (ROWS < 1) || (COLS < 1)) begin : g_bad_geometry
            $error("grid_scan_reader: ROWS*COLS must be in 1..256");
        end
    endgenerate

    localparam logic [2:0] c_idle    = 3'd0;
    localparam logic [2:0] c_addr    = 3'd1;
    localparam logic [2:0] c_data    = 3'd2;
    localparam logic [2:0] c_present = 3'd3;
    localparam logic [2:0] c_done    = 3'd4;

    localparam logic [7:0] c_last_col = 8'(COLS - 1);
    localparam logic [7:0] c_last_row = 8'(ROWS - 1);

    logic [2:0] r_state;
    logic [7:0] r_addr;
    logic [7:0] r_row;
    logic [7:0] r_col;
    logic [7:0] r_pix_data;

    logic       w_accept;
    logic       w_last_cell;
    logic       w_last_col;

    assign w_accept    = (r_state == c_present) && pix_ready;
    assign w_last_col  = (r_col == c_last_col);
    assign w_last_cell = w_last_col && (r_row == c_last_row);

    // Scan sequencer: one ADDR/DATA/PRESENT triplet per cell, counters advance on accept.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= c_idle;
            r_addr     <= 8'd0;
            r_row      <= 8'd0;
            r_col      <= 8'd0;
            r_pix_data <= 8'd0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (frame_req) begin
                        r_state <= c_addr;
                        r_addr  <= 8'd0;
                        r_row   <= 8'd0;
                        r_col   <= 8'd0;
                    end
                end
                c_addr: begin
                    r_state <= c_data;
                end
                c_data: begin
                    // Memory returns the byte one cycle after the strobe.
                    r_pix_data <= tetris_grid_in;
                    r_state    <= c_present;
                end
                c_present: begin
                    if (w_accept) begin
                        if (w_last_cell) begin
                            // Counters cleared so the address never runs past the grid.
                            r_state <= c_done;
                            r_addr  <= 8'd0;
                            r_row   <= 8'd0;
                            r_col   <= 8'd0;
                        end else begin
                            r_state <= c_addr;
                            r_addr  <= r_addr + 8'd1;
                            if (w_last_col) begin
                                r_col <= 8'd0;
                                r_row <= r_row + 8'd1;
                            end else begin
                                r_col <= r_col + 8'd1;
                            end
                        end
                    end
                end
                c_done: begin
                    r_state <= c_idle;
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

    // Outputs decoded from state; data and qualifiers hold while PRESENT stalls.
    always_comb begin
        grid_address = r_addr;
        read_en      = (r_state == c_addr);
        pix_data     = r_pix_data;
        pix_valid    = (r_state == c_present);
        pix_sof      = (r_state == c_present) && (r_addr == 8'd0);
        pix_eol      = (r_state == c_present) && w_last_col;
        busy         = (r_state != c_idle);
        frame_done   = (r_state == c_done);
    end

endmodule
`default_nettype wire
